// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the execute bundle until the data-SRAM
// response arrives, extends load data and hands the result to writeback.
module mem_stage #(
    parameter int IN_W  = 79,
    parameter int OUT_W = 72
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_to_mem_valid,
    input  logic [IN_W-1:0]  ex_to_mem_bus,
    output logic             mem_allowin,
    output logic [1:0]       mem_to_ex_bus,
    output logic [38:0]      mem_to_id_bus,
    input  logic             wb_allowin,
    output logic             mem_to_wb_valid,
    output logic [OUT_W-1:0] mem_to_wb_bus,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    input  logic             flush
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t          state_q;
    logic            valid_q;
    logic [IN_W-1:0] bus_q;
    logic            discard_q;
    logic            buf_valid_q;
    logic [31:0]     buf_q;

    logic [31:0] pc;
    logic        res_from_mem, rf_we, op_b, op_h, op_u, excep_en, ertn, mem_req;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [1:0]  byte_off;

    assign pc           = bus_q[78:47];
    assign res_from_mem = bus_q[46];
    assign rf_we        = bus_q[45];
    assign rf_waddr     = bus_q[44:40];
    assign alu_result   = bus_q[39:8];
    assign byte_off     = bus_q[7:6];
    assign op_b         = bus_q[5];
    assign op_h         = bus_q[4];
    assign op_u         = bus_q[3];
    assign excep_en     = bus_q[2];
    assign ertn         = bus_q[1];
    assign mem_req      = bus_q[0];

    logic ready_go, capture, next_wait, data_hit;

    assign data_hit    = data_sram_data_ok & ~discard_q;
    assign ready_go    = ~mem_req | buf_valid_q | data_hit;
    assign mem_allowin = ~valid_q | (ready_go & wb_allowin);
    assign capture     = ex_to_mem_valid & mem_allowin;
    assign next_wait   = capture & ex_to_mem_bus[0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            bus_q       <= '0;
            discard_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            if (capture) bus_q <= ex_to_mem_bus;
            if (flush) begin
                valid_q     <= 1'b0;
                state_q     <= S_IDLE;
                buf_valid_q <= 1'b0;
                // An outstanding request with no response yet leaves one data_ok to swallow
                discard_q   <= ((state_q == S_WAIT) | discard_q) & ~data_sram_data_ok;
            end else begin
                if (mem_allowin) valid_q <= ex_to_mem_valid;
                if (data_sram_data_ok & discard_q) discard_q <= 1'b0;
                case (state_q)
                    S_IDLE: if (next_wait) state_q <= S_WAIT;
                    S_WAIT: begin
                        if (data_hit) begin
                            if (wb_allowin) begin
                                state_q <= next_wait ? S_WAIT : S_IDLE;
                            end else begin
                                state_q     <= S_HOLD;
                                buf_q       <= data_sram_rdata;
                                buf_valid_q <= 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (wb_allowin) begin
                            buf_valid_q <= 1'b0;
                            state_q     <= next_wait ? S_WAIT : S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    logic [31:0] ld_src, ld_ext, final_result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_src  = buf_valid_q ? buf_q : data_sram_rdata;
    assign ld_half = byte_off[1] ? ld_src[31:16] : ld_src[15:0];

    always_comb begin
        ld_byte = ld_src[7:0];
        case (byte_off)
            2'd0: ld_byte = ld_src[7:0];
            2'd1: ld_byte = ld_src[15:8];
            2'd2: ld_byte = ld_src[23:16];
            2'd3: ld_byte = ld_src[31:24];
            default: ld_byte = ld_src[7:0];
        endcase
    end

    always_comb begin
        ld_ext = ld_src;
        if (op_b)      ld_ext = {{24{ld_byte[7] & ~op_u}}, ld_byte};
        else if (op_h) ld_ext = {{16{ld_half[15] & ~op_u}}, ld_half};
    end

    assign final_result = res_from_mem ? ld_ext : alu_result;

    logic load_pending;
    assign load_pending = valid_q & res_from_mem & ~ready_go;

    assign mem_to_ex_bus   = {excep_en & valid_q, ertn & valid_q};
    assign mem_to_id_bus   = {load_pending, rf_we & valid_q, rf_waddr, final_result};
    assign mem_to_wb_valid = valid_q & ready_go & ~flush;
    assign mem_to_wb_bus   = {pc, rf_we & valid_q, rf_waddr, final_result, excep_en, ertn};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected writeback bundles into
// a queue, a negedge monitor pops and compares each handoff.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_to_mem_valid;
    logic [78:0] ex_to_mem_bus;
    logic        mem_allowin;
    logic [1:0]  mem_to_ex_bus;
    logic [38:0] mem_to_id_bus;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [71:0] mem_to_wb_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .mem_allowin       (mem_allowin),
        .mem_to_ex_bus     (mem_to_ex_bus),
        .mem_to_id_bus     (mem_to_id_bus),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [71:0] sb_q[$];

    function automatic logic [78:0] mk_in(input logic [31:0] pc, input logic rfm, input logic we,
                                          input logic [4:0] wa, input logic [31:0] alu,
                                          input logic [1:0] boff, input logic b, input logic h,
                                          input logic u, input logic exc, input logic ert,
                                          input logic req);
        return {pc, rfm, we, wa, alu, boff, b, h, u, exc, ert, req};
    endfunction

    function automatic logic [71:0] exp_wb(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                           input logic [31:0] res, input logic exc, input logic ert);
        return {pc, we, wa, res, exc, ert};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor;
        forever begin
            @(negedge clk);
            if (resetn && mem_to_wb_valid && wb_allowin) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got %h, wanted no bundle", mem_to_wb_bus);
                end else begin
                    chk("sb_wb_bus", mem_to_wb_bus, sb_q.pop_front());
                end
            end
        end
    endtask

    task automatic issue(input logic [78:0] b);
        int n;
        n = 0;
        ex_to_mem_bus   = b;
        ex_to_mem_valid = 1'b1;
        #1;
        while (!mem_allowin && n < 20) begin
            tick;
            n++;
        end
        if (n == 20) chk("issue_timeout", 72'(mem_allowin), 72'(1));
        tick;
        ex_to_mem_valid = 1'b0;
    endtask

    // Load with response in the cycle right after capture
    task automatic quick_load(input logic [78:0] b, input logic [31:0] rd, input logic [71:0] exp,
                              input string name);
        sb_q.push_back(exp);
        issue(b);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #3 chk(name, 72'(mem_to_wb_valid), 72'(1));
        tick;
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn            = 1'b0;
        ex_to_mem_valid   = 1'b0;
        ex_to_mem_bus     = '0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        flush             = 1'b0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout, wanted completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) tick;
        #2;
        chk("rst_allowin", 72'(mem_allowin), 72'(1));
        chk("rst_wb_valid", 72'(mem_to_wb_valid), 72'(0));
        chk("rst_wb_bus", mem_to_wb_bus, 72'(0));
        chk("rst_id_bus", 72'(mem_to_id_bus), 72'(0));
        chk("rst_ex_bus", 72'(mem_to_ex_bus), 72'(0));
        tick;
        resetn = 1'b1;
        tick;

        // ld.b, byte_off=3, response two cycles after capture
        sb_q.push_back(exp_wb(32'h1000, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b0));
        issue(mk_in(32'h1000, 1, 1, 5'd5, 32'h2003, 2'd3, 1, 0, 0, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("ldb_wait_valid", 72'(mem_to_wb_valid), 72'(0));
            chk("ldb_load_pending", 72'(mem_to_id_bus[38]), 72'(1));
            chk("ldb_allowin", 72'(mem_allowin), 72'(0));
            tick;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80AB_CDEF;
        #3;
        chk("ldb_out_valid", 72'(mem_to_wb_valid), 72'(1));
        chk("ldb_pending_clr", 72'(mem_to_id_bus[38]), 72'(0));
        chk("ldb_id_result", 72'(mem_to_id_bus[31:0]), 72'(32'hFFFF_FF80));
        tick;
        data_sram_data_ok = 1'b0;
        #3 chk("ldb_drained", 72'(mem_to_wb_valid), 72'(0));
        tick;

        quick_load(mk_in(32'h1010, 1, 1, 5'd6, 32'h0, 2'd2, 0, 1, 1, 0, 0, 1), 32'hBEEF_1234,
                   exp_wb(32'h1010, 1, 5'd6, 32'h0000_BEEF, 0, 0), "ldhu_valid");
        quick_load(mk_in(32'h1014, 1, 1, 5'd7, 32'h0, 2'd2, 0, 1, 0, 0, 0, 1), 32'hBEEF_1234,
                   exp_wb(32'h1014, 1, 5'd7, 32'hFFFF_BEEF, 0, 0), "ldh_valid");
        quick_load(mk_in(32'h1018, 1, 1, 5'd8, 32'h0, 2'd1, 1, 0, 1, 0, 0, 1), 32'h1234_A5CD,
                   exp_wb(32'h1018, 1, 5'd8, 32'h0000_00A5, 0, 0), "ldbu_valid");
        quick_load(mk_in(32'h101C, 1, 1, 5'd9, 32'h0, 2'd0, 0, 1, 0, 0, 0, 1), 32'h1234_7FFE,
                   exp_wb(32'h101C, 1, 5'd9, 32'h0000_7FFE, 0, 0), "ldh_pos_valid");

        // Response arrives while writeback is stalled: result must come from the buffer
        sb_q.push_back(exp_wb(32'h1100, 1, 5'd10, 32'hCAFE_F00D, 0, 0));
        wb_allowin = 1'b0;
        issue(mk_in(32'h1100, 1, 1, 5'd10, 32'h0, 2'd0, 0, 0, 0, 0, 0, 1));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("hold_valid", 72'(mem_to_wb_valid), 72'(1));
            chk("hold_result", 72'(mem_to_wb_bus[33:2]), 72'(32'hCAFE_F00D));
            chk("hold_allowin", 72'(mem_allowin), 72'(0));
            tick;
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'hDEAD_DEAD;
        end
        wb_allowin = 1'b1;
        #3 chk("hold_release", 72'(mem_to_wb_valid), 72'(1));
        tick;
        #3 chk("hold_drained", 72'(mem_to_wb_valid), 72'(0));
        tick;

        // Flush in WAIT: the first response belongs to the killed load
        issue(mk_in(32'h1200, 1, 1, 5'd11, 32'h0, 2'd0, 0, 0, 0, 0, 0, 1));
        flush = 1'b1;
        #3 chk("flush_kill", 72'(mem_to_wb_valid), 72'(0));
        tick;
        flush = 1'b0;
        sb_q.push_back(exp_wb(32'h1300, 1, 5'd12, 32'h0000_2222, 0, 0));
        issue(mk_in(32'h1300, 1, 1, 5'd12, 32'h0, 2'd0, 0, 0, 0, 0, 0, 1));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_1111;
        #3 chk("discard_first", 72'(mem_to_wb_valid), 72'(0));
        tick;
        data_sram_data_ok = 1'b0;
        #3 chk("discard_wait", 72'(mem_to_id_bus[38]), 72'(1));
        tick;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_2222;
        #3 chk("discard_second", 72'(mem_to_wb_valid), 72'(1));
        tick;
        data_sram_data_ok = 1'b0;
        tick;

        // Back-to-back ALU bundles, one per cycle
        ex_to_mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex_to_mem_bus = mk_in(32'h2000 + 32'(4 * i), 0, 1, 5'(i + 1), 32'h1234 + 32'(i),
                                  2'd0, 0, 0, 0, 0, 0, 0);
            sb_q.push_back(exp_wb(32'h2000 + 32'(4 * i), 1, 5'(i + 1), 32'h1234 + 32'(i), 0, 0));
            tick;
            #3;
            chk("b2b_valid", 72'(mem_to_wb_valid), 72'(1));
            chk("b2b_pending", 72'(mem_to_id_bus[38]), 72'(0));
            chk("b2b_allowin", 72'(mem_allowin), 72'(1));
        end
        ex_to_mem_valid = 1'b0;
        tick;
        #3 chk("b2b_drained", 72'(mem_to_wb_valid), 72'(0));
        tick;

        // Exception and ertn bundles bypass the data_ok wait
        sb_q.push_back(exp_wb(32'h3000, 0, 5'd0, 32'h0000_DEAD, 1, 0));
        issue(mk_in(32'h3000, 0, 0, 5'd0, 32'h0000_DEAD, 2'd0, 0, 0, 0, 1, 0, 0));
        #3;
        chk("excep_ex_bus", 72'(mem_to_ex_bus), 72'(2'b10));
        chk("excep_valid", 72'(mem_to_wb_valid), 72'(1));
        tick;
        #3 chk("excep_ex_clr", 72'(mem_to_ex_bus), 72'(0));
        tick;
        sb_q.push_back(exp_wb(32'h3004, 0, 5'd0, 32'h0, 0, 1));
        issue(mk_in(32'h3004, 0, 0, 5'd0, 32'h0, 2'd0, 0, 0, 0, 0, 1, 0));
        #3 chk("ertn_ex_bus", 72'(mem_to_ex_bus), 72'(2'b01));
        tick;

        // Store waits for data_ok but reports alu_result and no load hazard
        sb_q.push_back(exp_wb(32'h4000, 0, 5'd0, 32'h0000_4444, 0, 0));
        issue(mk_in(32'h4000, 0, 0, 5'd0, 32'h4444, 2'd0, 0, 0, 0, 0, 0, 1));
        #3;
        chk("st_wait", 72'(mem_to_wb_valid), 72'(0));
        chk("st_no_pending", 72'(mem_to_id_bus[38]), 72'(0));
        tick;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        #3 chk("st_done", 72'(mem_to_wb_valid), 72'(1));
        tick;
        data_sram_data_ok = 1'b0;
        tick;

        // Reset while waiting; a fresh load afterwards must take the first data_ok
        issue(mk_in(32'h5000, 1, 1, 5'd13, 32'h0, 2'd0, 0, 0, 0, 0, 0, 1));
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        #3;
        chk("rst_mid_allowin", 72'(mem_allowin), 72'(1));
        chk("rst_mid_valid", 72'(mem_to_wb_valid), 72'(0));
        tick;
        quick_load(mk_in(32'h5004, 1, 1, 5'd14, 32'h0, 2'd0, 0, 0, 0, 0, 0, 1), 32'h1357_9BDF,
                   exp_wb(32'h5004, 1, 5'd14, 32'h1357_9BDF, 0, 0), "post_rst_valid");

        repeat (3) tick;
        chk("sb_empty", 72'(sb_q.size()), 72'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
